// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation comparator controller.
package sar_pkg;

    localparam int unsigned SAR_WIDTH_DEFAULT = 4;
    localparam int unsigned SAR_STATE_W       = 2;

    typedef enum logic [SAR_STATE_W-1:0] {
        StIdle,
        StTest,
        StDone,
        StSettle
    } sar_state_e;

endpackage

// File: rtl/sar_cmpge_ctrl_if.sv
// Comparator-side bundle of the SAR controller: start/result handshake plus trial/cmp_ge loop.
interface sar_cmpge_ctrl_if import sar_pkg::*; #(
    parameter int unsigned WIDTH = SAR_WIDTH_DEFAULT
) ();

    logic             start;
    logic             cmp_ge;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output cmp_ge,
        input  trial,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  cmp_ge,
        output trial,
        output busy,
        output done,
        output result
    );

endinterface

// File: rtl/sar_bit_ptr.sv
// One-hot bit pointer for the SAR search: loads the MSB, shifts right once per decision.
module sar_bit_ptr import sar_pkg::*; #(
    parameter int unsigned WIDTH = SAR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] ptr_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] MsbOne = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = MsbOne;
        end else if (shift_i) begin
            ptr_d = ptr_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = ptr_q[0];

endmodule

// File: rtl/sar_cmpge_ctrl.sv
// MSB-first SAR controller driving an external a >= trial comparator.
// Define SAR_SETTLE_EN to add a one-cycle SETTLE state before each decision.
module sar_cmpge_ctrl import sar_pkg::*; #(
    parameter int unsigned WIDTH = SAR_WIDTH_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    sar_cmpge_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] MsbOne = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SAR_SETTLE_EN
    localparam sar_state_e StBit = StSettle;
`else
    localparam sar_state_e StBit = StTest;
`endif

    sar_state_e       state_d, state_q;
    logic [WIDTH-1:0] trial_d, trial_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic             ptr_load, ptr_shift, ptr_last;
    logic [WIDTH-1:0] ptr, ptr_next, decided;

    sar_bit_ptr #(
        .WIDTH (WIDTH)
    ) u_bit_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ptr_load),
        .shift_i (ptr_shift),
        .ptr_o   (ptr),
        .last_o  (ptr_last)
    );

    assign ptr_next = ptr >> 1;
    // Bit under test survives only if a >= trial; cmp_ge is a don't-care outside TEST.
    assign decided  = bus.cmp_ge ? trial_q : (trial_q & ~ptr);

    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ptr_load  = 1'b0;
        ptr_shift = 1'b0;
        case (state_q)
            StIdle: begin
                trial_d = '0;
                busy_d  = 1'b0;
                if (bus.start) begin
                    trial_d  = MsbOne;
                    busy_d   = 1'b1;
                    ptr_load = 1'b1;
                    state_d  = StBit;
                end
            end
            StTest: begin
                if (ptr_last) begin
                    trial_d  = decided;
                    result_d = decided;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StDone;
                end else begin
                    trial_d   = decided | ptr_next;
                    ptr_shift = 1'b1;
                    state_d   = StBit;
                end
            end
            StDone: begin
                if (bus.start) begin
                    trial_d  = MsbOne;
                    busy_d   = 1'b1;
                    ptr_load = 1'b1;
                    state_d  = StBit;
                end else begin
                    trial_d = '0;
                    state_d = StIdle;
                end
            end
`ifdef SAR_SETTLE_EN
            StSettle: begin
                state_d = StTest;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_sar_cmpge_ctrl.sv
// Scoreboard bench for sar_cmpge_ctrl with a behavioural a >= trial comparator.
module tb_sar_cmpge_ctrl;

    localparam int unsigned W = 4;
`ifdef SAR_SETTLE_EN
    localparam int unsigned Reps = 2;
`else
    localparam int unsigned Reps = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a_r;
    logic         armed;
    logic         prev_done;
    int           busy_cnt;
    int           vectors;
    int           miscompares;

    logic [W-1:0] exp_trial[$];
    logic [W-1:0] exp_res[$];

    sar_cmpge_ctrl_if #(.WIDTH(W)) bus ();

    assign bus.cmp_ge = (a_r >= bus.trial);

    sar_cmpge_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: during step i the decided prefix equals a's bits above i, with bit i probed.
    task automatic push_expect(input int val, input bit with_result);
        logic [W-1:0] t;
        for (int i = W - 1; i >= 0; i--) begin
            t = W'(((val >> (i + 1)) << (i + 1)) | (1 << i));
            for (int r = 0; r < int'(Reps); r++) exp_trial.push_back(t);
        end
        if (with_result) exp_res.push_back(W'(val));
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 4 * W * Reps + 8);
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    task automatic run(input int val);
        a_r = W'(val);
        bus.start = 1'b1;
        push_expect(val, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
    endtask

    always @(negedge clk) begin
        if (armed && rst_n) begin
            if (bus.busy) begin
                busy_cnt++;
                if (exp_trial.size() == 0) check("trial_underflow", 1, 0);
                else check("trial", bus.trial, exp_trial.pop_front());
            end else if (bus.done) begin
                check("busy_len", busy_cnt, W * Reps);
                check("done_pulse", prev_done, 0);
                if (exp_res.size() == 0) begin
                    check("result_underflow", 1, 0);
                end else begin
                    logic [W-1:0] r;
                    r = exp_res.pop_front();
                    check("result", bus.result, r);
                    check("done_trial", bus.trial, r);
                end
                busy_cnt = 0;
            end else begin
                check("idle_trial", bus.trial, 0);
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        busy_cnt    = 0;
        prev_done   = 1'b0;
        armed       = 1'b0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        a_r         = '0;
        repeat (3) @(negedge clk);
        check("rst_trial", bus.trial, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        rst_n = 1'b1;
        armed = 1'b1;
        @(negedge clk);

        run(9);
        @(negedge clk);
        run(0);
        @(negedge clk);
        run(15);
        @(negedge clk);

        // start held through two conversions: mid-TEST start ignored, restart from DONE
        a_r = W'(5);
        bus.start = 1'b1;
        push_expect(5, 1'b1);
        push_expect(5, 1'b1);
        wait_done();
        wait_done();
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // asynchronous reset after the second decision
        a_r = W'(6);
        bus.start = 1'b1;
        push_expect(6, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2 * Reps) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trial", bus.trial, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_result", bus.result, 0);
        exp_trial.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run(3);

        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(int'($urandom_range(0, (1 << W) - 1)));
        end
        repeat (3) @(negedge clk);
        check("trial_q_empty", exp_trial.size(), 0);
        check("result_q_empty", exp_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
